// File: rtl/bus_demux_regbank_pkg.sv
// Shared constants and helpers for the 8-entry write-side register bank.
// Optional build macro: UL8_REG0_ZERO_EN (register 0 hardwired to zero).
package ul8_bus_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int SEL_W      = 3;
  localparam int NUM_REGS   = 8;

  localparam logic [SEL_W-1:0] REG_0 = 3'd0;
  localparam logic [SEL_W-1:0] REG_1 = 3'd1;
  localparam logic [SEL_W-1:0] REG_2 = 3'd2;
  localparam logic [SEL_W-1:0] REG_3 = 3'd3;
  localparam logic [SEL_W-1:0] REG_4 = 3'd4;
  localparam logic [SEL_W-1:0] REG_5 = 3'd5;
  localparam logic [SEL_W-1:0] REG_6 = 3'd6;
  localparam logic [SEL_W-1:0] REG_7 = 3'd7;

  function automatic logic [NUM_REGS-1:0] sel_hot(
    input logic [SEL_W-1:0] s
  );
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/bus_demux_regbank_if.sv
// Write port, commit/clear controls and bank outputs of the register bank.
// slave: seen by the bank; master: seen by the producer / bus mux side.
interface bus_demux_regbank_if
  import ul8_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic                wr_valid;
  logic [SEL_W-1:0]    wr_sel;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_ready;
  logic                commit_en;
  logic                clr_dirty;
  logic [NUM_REGS-1:0] dirty;
  logic                pending;
  logic [DATA_W-1:0]   out_0;
  logic [DATA_W-1:0]   out_1;
  logic [DATA_W-1:0]   out_2;
  logic [DATA_W-1:0]   out_3;
  logic [DATA_W-1:0]   out_4;
  logic [DATA_W-1:0]   out_5;
  logic [DATA_W-1:0]   out_6;
  logic [DATA_W-1:0]   out_7;

  modport slave (
    input  wr_valid, wr_sel, wr_data,
    input  commit_en, clr_dirty,
    output wr_ready, dirty, pending,
    output out_0, out_1, out_2, out_3,
    output out_4, out_5, out_6, out_7
  );

  modport master (
    output wr_valid, wr_sel, wr_data,
    output commit_en, clr_dirty,
    input  wr_ready, dirty, pending,
    input  out_0, out_1, out_2, out_3,
    input  out_4, out_5, out_6, out_7
  );

endinterface

// File: rtl/bus_demux_regbank_stage.sv
// One-entry valid/ready staging slot: accepts a write, holds it until retired.
// Ports: in_* write port, take_i retire permit, pend/sel/data staged entry, retire_o.
module bus_stage
  import ul8_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [SEL_W-1:0]  in_sel_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              take_i,
  output logic              pend_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [DATA_W-1:0] data_o,
  output logic              retire_o
);

  logic              pend_q, pend_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  // A retiring entry frees the slot in the same cycle.
  assign in_ready_o = !pend_q || take_i;
  assign accept     = in_valid_i && in_ready_o;
  assign retire_o   = pend_q && take_i;

  always_comb begin
    pend_d = pend_q;
    sel_d  = sel_q;
    data_d = data_q;
    if (accept) begin
      pend_d = 1'b1;
      sel_d  = in_sel_i;
      data_d = in_data_i;
    end else if (retire_o) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  assign pend_o = pend_q;
  assign sel_o  = sel_q;
  assign data_o = data_q;

endmodule

// File: rtl/bus_demux_regbank.sv
// Routes one staged bus value into one of 8 registers on commit; tracks dirty.
// Ports: clk, rst (sync, active-high), bus (slave). Macro: UL8_REG0_ZERO_EN.
module bus_demux_regbank
  import ul8_bus_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  bus_demux_regbank_if.slave  bus
);

  logic              retire;
  logic              stg_pend;
  logic [SEL_W-1:0]  stg_sel;
  logic [DATA_W-1:0] stg_data;

  bus_stage #(
    .DATA_W (DATA_W)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (bus.wr_valid),
    .in_sel_i   (bus.wr_sel),
    .in_data_i  (bus.wr_data),
    .in_ready_o (bus.wr_ready),
    .take_i     (bus.commit_en),
    .pend_o     (stg_pend),
    .sel_o      (stg_sel),
    .data_o     (stg_data),
    .retire_o   (retire)
  );

  logic [DATA_W-1:0]   bank_q [NUM_REGS];
  logic [DATA_W-1:0]   bank_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [NUM_REGS-1:0] wr_hot;

  always_comb begin
    wr_hot = '0;
    if (retire) begin
      wr_hot = sel_hot(stg_sel);
    end
`ifdef UL8_REG0_ZERO_EN
    // Commit to reg 0 still retires, but lands nowhere.
    wr_hot[REG_0] = 1'b0;
`endif
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      bank_d[i] = bank_q[i];
      if (wr_hot[i]) begin
        bank_d[i] = stg_data;
      end
    end
  end

  // Commit beats clear on the same edge.
  always_comb begin
    dirty_d = bus.clr_dirty ? '0 : dirty_q;
    dirty_d = dirty_d | wr_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= RESET_VAL;
      end
      dirty_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= bank_d[i];
      end
      dirty_q <= dirty_d;
    end
  end

  assign bus.dirty   = dirty_q;
  assign bus.pending = stg_pend;

`ifdef UL8_REG0_ZERO_EN
  assign bus.out_0 = '0;
`else
  assign bus.out_0 = bank_q[REG_0];
`endif
  assign bus.out_1 = bank_q[REG_1];
  assign bus.out_2 = bank_q[REG_2];
  assign bus.out_3 = bank_q[REG_3];
  assign bus.out_4 = bank_q[REG_4];
  assign bus.out_5 = bank_q[REG_5];
  assign bus.out_6 = bank_q[REG_6];
  assign bus.out_7 = bank_q[REG_7];

endmodule

// File: tb/tb_bus_demux_regbank.sv
// Directed + random bench for bus_demux_regbank against a behavioural model.
// Honours UL8_REG0_ZERO_EN in the model when the build defines it.
module tb_bus_demux_regbank;
  import ul8_bus_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_demux_regbank_if #(.DATA_W(W)) bus();

  bus_demux_regbank #(
    .DATA_W    (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: eight registers, sticky dirty set, one-deep staging slot.
  logic [W-1:0] m_reg [8];
  logic [7:0]   m_dirty;
  bit           m_pend;
  int           m_sel;
  logic [W-1:0] m_data;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [W-1:0] get_out(input int i);
    case (i)
      0: return bus.out_0;
      1: return bus.out_1;
      2: return bus.out_2;
      3: return bus.out_3;
      4: return bus.out_4;
      5: return bus.out_5;
      6: return bus.out_6;
      default: return bus.out_7;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, got, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_dirty = '0;
    m_pend  = 0;
  endtask

  // Drive one cycle (called at negedge), then check state after the edge.
  task automatic step(input bit v, input int s,
                      input logic [W-1:0] d,
                      input bit c, input bit clr,
                      input bit r);
    bit acc, com, land;
    rst           = r;
    bus.wr_valid  = v;
    bus.wr_sel    = 3'(s);
    bus.wr_data   = d;
    bus.commit_en = c;
    bus.clr_dirty = clr;
    #1;
    chk("wr_ready", 32'(bus.wr_ready),
        32'(!m_pend || c));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      acc = v && (!m_pend || c);
      com = m_pend && c;
      if (clr) m_dirty = '0;
      land = com;
`ifdef UL8_REG0_ZERO_EN
      if (m_sel == 0) land = 0;
`endif
      if (land) begin
        m_reg[m_sel]   = m_data;
        m_dirty[m_sel] = 1'b1;
      end
      if (acc) begin
        m_pend = 1;
        m_sel  = s;
        m_data = d;
      end else if (com) begin
        m_pend = 0;
      end
    end
    #1;
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("dirty", 32'(bus.dirty), 32'(m_dirty));
    for (int i = 0; i < 8; i++)
      chk($sformatf("out_%0d", i),
          32'(get_out(i)), 32'(m_reg[i]));
    @(negedge clk);
  endtask

  task automatic idle(input bit c);
    step(0, 0, 8'h00, c, 0, 0);
  endtask

  initial begin
    bus.wr_valid  = 0;
    bus.wr_sel    = '0;
    bus.wr_data   = '0;
    bus.commit_en = 0;
    bus.clr_dirty = 0;
    m_reset();
    @(negedge clk);

    // 1: reset then idle
    step(0, 0, 8'h00, 0, 0, 1);
    idle(0);
    chk("t1_dirty", 32'(bus.dirty), 32'h0);
    chk("t1_pend", 32'(bus.pending), 32'h0);
    chk("t1_out3", 32'(bus.out_3), 32'h0);
    #1;
    chk("t1_ready", 32'(bus.wr_ready), 32'h1);

    // 2: accept sel5, commit next cycle
    step(1, 5, 8'hA5, 0, 0, 0);
    chk("t2_out5_early", 32'(bus.out_5), 32'h0);
    step(0, 0, 8'h00, 1, 0, 0);
    chk("t2_out5", 32'(bus.out_5), 32'hA5);
    chk("t2_dirty", 32'(bus.dirty), 32'h20);

    // 3: stall with commit_en=0, then drain
    step(1, 2, 8'h3C, 0, 0, 0);
    step(1, 4, 8'h77, 0, 0, 0);
    chk("t3_stall_out2", 32'(bus.out_2), 32'h0);
    step(1, 4, 8'h77, 1, 0, 0);
    chk("t3_out2", 32'(bus.out_2), 32'h3C);
    chk("t3_pend", 32'(bus.pending), 32'h1);
    idle(1);
    chk("t3_out4", 32'(bus.out_4), 32'h77);

    // 4: back-to-back writes
    for (int i = 0; i < 8; i++)
      step(1, i, 8'(8'h10 + i), 1, 0, 0);
    idle(1);
    chk("t4_out7", 32'(bus.out_7), 32'h17);

    // 5: clear and commit on the same edge
    step(1, 3, 8'h33, 0, 0, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    chk("t5_dirty", 32'(bus.dirty), 32'h08);

    // 6: reset discards staged entry; then reg 0 write
    step(1, 6, 8'h99, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 1);
    idle(1);
    chk("t6_out6", 32'(bus.out_6), 32'h0);
    chk("t6_pend", 32'(bus.pending), 32'h0);
    step(1, 0, 8'hFF, 0, 0, 0);
    idle(1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)),
           8'($urandom),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
